// File: rtl/controller_compressor.sv
// Sequencing FSM for datapath_compressor: fill input buffer, prime lookahead, then loop
// match -> encode -> emit -> shift until the lookahead drains.
module controller_compressor #(
    parameter int unsigned LA_DEPTH = 6,
    parameter int unsigned IN_DEPTH = 31
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    input  logic in_last,
    output logic in_ready,
    input  logic eqz,
    input  logic end_of_data,
    output logic load_input,
    output logic load_lookahead,
    output logic load_seach,
    output logic slide_search,
    output logic match_check,
    output logic encode,
    output logic ld_length,
    output logic dec,
    output logic tok_valid,
    input  logic tok_ready,
    output logic busy,
    output logic done
);

    localparam int unsigned LaW  = $clog2(LA_DEPTH + 1);
    localparam int unsigned CntW = $clog2(IN_DEPTH + 1);

    typedef enum logic [3:0] {
        StIdle,
        StFill,
        StPrime,
        StMatch,
        StMwait,
        StEnc,
        StEmit,
        StShift,
        StDone
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LaW-1:0]    la_cnt_q, la_cnt_d;
    logic [LaW-1:0]    la_after_shift;
    logic              prime_q;
    logic              shift_q;

    // Lookahead occupancy after one SHIFT cycle: a refill keeps it level.
    assign la_after_shift = (end_of_data && la_cnt_q != '0) ? la_cnt_q - 1'b1 : la_cnt_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        la_cnt_d   = la_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StFill;
                    byte_cnt_d = '0;
                    la_cnt_d   = '0;
                end
            end
            StFill: begin
                if (in_valid) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (in_last || byte_cnt_q == CntW'(IN_DEPTH - 1)) begin
                        state_d = StPrime;
                    end
                end
            end
            StPrime: begin
                if (la_cnt_q == LaW'(LA_DEPTH) || end_of_data) begin
                    state_d = StMatch;
                end else begin
                    la_cnt_d = la_cnt_q + 1'b1;
                end
            end
            StMatch: state_d = StMwait;
            StMwait: state_d = StEnc;
            StEnc:   state_d = StEmit;
            StEmit: begin
                if (tok_ready) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                la_cnt_d = la_after_shift;
                // Data exhausted ends the block even if the length counter has not reached zero.
                if (la_after_shift == '0) begin
                    state_d = StDone;
                end else if (eqz) begin
                    state_d = StMatch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            la_cnt_q    <= '0;
            in_ready    <= 1'b0;
            prime_q     <= 1'b0;
            match_check <= 1'b0;
            encode      <= 1'b0;
            ld_length   <= 1'b0;
            tok_valid   <= 1'b0;
            shift_q     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            la_cnt_q    <= la_cnt_d;
            in_ready    <= (state_d == StFill);
            prime_q     <= (state_d == StPrime);
            match_check <= (state_d == StMatch);
            encode      <= (state_d == StEnc);
            ld_length   <= (state_d == StEnc);
            tok_valid   <= (state_d == StEmit);
            shift_q     <= (state_d == StShift);
            busy        <= (state_d != StIdle);
            done        <= (state_q == StDone);
        end
    end

    // Strobes qualified by datapath status are gated from the registered state flags.
    assign load_input     = in_ready & in_valid;
    assign load_lookahead = (prime_q & ~end_of_data & (la_cnt_q < LaW'(LA_DEPTH)))
                          | (shift_q & ~end_of_data);
    assign load_seach     = shift_q;
    assign slide_search   = shift_q;
    assign dec            = shift_q & ~eqz;

endmodule
